// File: rtl/imem_ctrl_pkg.sv
// Shared defaults, FSM state type and length clamp for the imem program loader.
package imem_ctrl_pkg;

   localparam int unsigned IMEM_AW_DFLT    = 6;
   localparam int unsigned IMEM_DEPTH_DFLT = 64;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StChk,
      StRun,
      StErr
   } state_e;

   function automatic logic [6:0] clamp_len(input logic [6:0] len, input int unsigned depth);
      if (32'(len) > depth) begin
         return 7'(depth);
      end
      return len;
   endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader-side and CPU-side signals of imem_load_ctrl; slave = controller, master = driver.
interface imem_load_ctrl_if
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned IMEM_AW = IMEM_AW_DFLT
) ();

   logic               load_start;
   logic [6:0]         load_len;
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic [31:0]        cpu_pc;
   logic [IMEM_AW-1:0] imem_a;
   logic [31:0]        imem_wd;
   logic               imem_we;
   logic               cpu_run;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output load_start, load_len, rx_data, rx_valid, cpu_pc,
      input  rx_ready, imem_a, imem_wd, imem_we, cpu_run, busy, done, err
   );

   modport slave (
      input  load_start, load_len, rx_data, rx_valid, cpu_pc,
      output rx_ready, imem_a, imem_wd, imem_we, cpu_run, busy, done, err
   );

endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; word_vld_o pulses the cycle after the 4th byte lands.
module byte_packer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_vld_i,
   output logic [1:0]  cnt_o,
   output logic [31:0] word_o,
   output logic        word_vld_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic        vld_q, vld_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      vld_d  = 1'b0;
      if (clr_i) begin
         cnt_d = 2'd0;
      end else if (byte_vld_i) begin
         word_d = {word_q[23:0], byte_i};
         cnt_d  = cnt_q + 2'd1;
         vld_d  = (cnt_q == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
         vld_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
         vld_q  <= vld_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign word_o     = word_q;
   assign word_vld_o = vld_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Serial program loader for the instruction memory; holds the CPU until the load completes.
// Define IMEM_CHECKSUM_EN to add a trailing XOR-checksum word check (CHK/ERR states).
module imem_load_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int unsigned IMEM_AW    = IMEM_AW_DFLT,
   parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DFLT
) (
   input logic             clk,
   input logic             reset_n,
   imem_load_ctrl_if.slave ctrl_if
);

   state_e             state_q;
   logic [IMEM_AW-1:0] wcnt_q;
   logic [6:0]         len_q;
   logic               rx_ready_q, cpu_run_q, busy_q, done_q;
   logic [1:0]         pk_cnt;
   logic [31:0]        pk_word;
   logic               pk_vld;
   logic               accept, start_ok, last_word;
   logic [6:0]         len_clamped;

   assign accept      = ctrl_if.rx_valid && rx_ready_q;
   assign start_ok    = ctrl_if.load_start &&
                        (state_q == StIdle || state_q == StRun || state_q == StErr);
   assign len_clamped = clamp_len(ctrl_if.load_len, IMEM_DEPTH);
   assign last_word   = (7'(wcnt_q) == len_q - 7'd1);

   byte_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (start_ok),
      .byte_i    (ctrl_if.rx_data),
      .byte_vld_i(accept),
      .cnt_o     (pk_cnt),
      .word_o    (pk_word),
      .word_vld_o(pk_vld)
   );

`ifdef IMEM_CHECKSUM_EN
   logic [31:0] csum_q;
   logic        err_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         wcnt_q     <= '0;
         len_q      <= 7'd0;
         rx_ready_q <= 1'b0;
         cpu_run_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
         csum_q     <= 32'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle, StRun, StErr: begin
               if (start_ok) begin
                  len_q     <= len_clamped;
                  wcnt_q    <= '0;
                  cpu_run_q <= 1'b0;
                  done_q    <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                  csum_q    <= 32'd0;
                  err_q     <= 1'b0;
`endif
                  if (len_clamped != 7'd0) begin
                     state_q    <= StLoad;
                     busy_q     <= 1'b1;
                     rx_ready_q <= 1'b1;
                  end else begin
`ifdef IMEM_CHECKSUM_EN
                     state_q    <= StChk;
                     busy_q     <= 1'b1;
                     rx_ready_q <= 1'b1;
`else
                     state_q    <= StRun;
                     cpu_run_q  <= 1'b1;
                     done_q     <= 1'b1;
`endif
                  end
               end
            end
            StLoad: begin
               // Close the byte port one cycle early so nothing lands during the final write.
               if (accept && pk_cnt == 2'd3 && last_word) rx_ready_q <= 1'b0;
               if (pk_vld) begin
`ifdef IMEM_CHECKSUM_EN
                  csum_q <= csum_q ^ pk_word;
`endif
                  if (last_word) begin
`ifdef IMEM_CHECKSUM_EN
                     state_q    <= StChk;
                     rx_ready_q <= 1'b1;
`else
                     state_q    <= StRun;
                     busy_q     <= 1'b0;
                     cpu_run_q  <= 1'b1;
                     done_q     <= 1'b1;
`endif
                  end else begin
                     wcnt_q <= wcnt_q + 1'b1;
                  end
               end
            end
`ifdef IMEM_CHECKSUM_EN
            StChk: begin
               if (accept && pk_cnt == 2'd3) rx_ready_q <= 1'b0;
               if (pk_vld) begin
                  busy_q <= 1'b0;
                  if (pk_word == csum_q) begin
                     state_q   <= StRun;
                     cpu_run_q <= 1'b1;
                     done_q    <= 1'b1;
                  end else begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

   logic unused_pc;
   assign unused_pc = ^{ctrl_if.cpu_pc[31:IMEM_AW+2], ctrl_if.cpu_pc[1:0]};

   assign ctrl_if.rx_ready = rx_ready_q;
   assign ctrl_if.imem_we  = pk_vld && (state_q == StLoad);
   assign ctrl_if.imem_wd  = pk_word;
   assign ctrl_if.imem_a   = (state_q == StRun) ? ctrl_if.cpu_pc[IMEM_AW+1:2] : wcnt_q;
   assign ctrl_if.cpu_run  = cpu_run_q;
   assign ctrl_if.busy     = busy_q;
   assign ctrl_if.done     = done_q;
`ifdef IMEM_CHECKSUM_EN
   assign ctrl_if.err      = err_q;
`else
   assign ctrl_if.err      = 1'b0;
`endif

endmodule
